// File: rtl/mat_pkg.sv
// Shared matrix types and geometry for the outer-product datapath.
// Element (r,c) sits at a fixed bit offset in the flat matrix bus.
package mat_pkg;

  localparam int DATA_LEN = 32;
  localparam int M = 8;
  localparam int N = 8;
  localparam int K = 8;

  typedef logic signed [DATA_LEN-1:0] elem_t;

  function automatic int elem_lsb(int r, int c);
    return DATA_LEN * N * r + DATA_LEN * c;
  endfunction

endpackage

// File: rtl/mat_outer_accum_if.sv
// Beat-in / matrix-out handshake bundle of the outer-product accumulator.
// The slave modport is the accumulator side; master is the driver side.
interface mat_outer_accum_if
  import mat_pkg::*;
#(
  parameter int DL = DATA_LEN,
  parameter int MR = M,
  parameter int NC = N,
  parameter int KB = K
);

  localparam int MS = DL * MR * NC;
  localparam int CW = $clog2(KB);

  logic          i_valid;
  logic          o_ready;
  logic [MS-1:0] i_mat_p;
  logic          i_clear;
  logic          o_valid;
  logic          i_ready;
  logic [MS-1:0] o_mat_c;
  logic [CW-1:0] o_beat_cnt;

  modport slave (
    input  i_valid, i_mat_p, i_clear, i_ready,
    output o_ready, o_valid, o_mat_c, o_beat_cnt
  );

  modport master (
    output i_valid, i_mat_p, i_clear, i_ready,
    input  o_ready, o_valid, o_mat_c, o_beat_cnt
  );

endinterface

// File: rtl/mat_acc_lane.sv
// One accumulator element: loads din or adds it to the held value.
// The sum wraps modulo 2^W.
module mat_acc_lane #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = load ? din : q_q + din;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mat_outer_accum.sv
// Sums K rank-1 partial products into C = A*B and holds the result
// in an output register while the next batch is accumulated.
module mat_outer_accum
  import mat_pkg::*;
#(
  parameter int DL = DATA_LEN,
  parameter int MR = M,
  parameter int NC = N,
  parameter int KB = K
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  mat_outer_accum_if.slave bus
);

  localparam int MS = DL * MR * NC;
  localparam int CW = $clog2(KB);
  localparam logic [CW-1:0] LAST = CW'(KB - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [MS-1:0] mat_q, mat_d;
  logic [MS-1:0] sum;
  logic          last, ready, fire, load;

  assign last  = (cnt_q == LAST);
  // Only the final beat can stall: it needs the output register free.
  assign ready = !bus.i_clear
               && !(last && valid_q && !bus.i_ready);
  assign fire  = bus.i_valid && ready;
  assign load  = (cnt_q == '0);

  for (genvar r = 0; r < MR; r++) begin : g_row
    for (genvar c = 0; c < NC; c++) begin : g_col
      localparam int LSB = DL * NC * r + DL * c;
      logic [DL-1:0] q;

      mat_acc_lane #(.W(DL)) u_lane (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .load  (load),
        .en    (fire),
        .din   (bus.i_mat_p[LSB +: DL]),
        .q     (q)
      );

      assign sum[LSB +: DL] = q + bus.i_mat_p[LSB +: DL];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    mat_d   = mat_q;
    if (bus.i_clear)
      cnt_d = '0;
    else if (fire)
      cnt_d = last ? '0 : cnt_q + 1'b1;
    if (fire && last) begin
      valid_d = 1'b1;
      mat_d   = sum;
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      mat_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      mat_q   <= mat_d;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_mat_c    = mat_q;
  assign bus.o_beat_cnt = cnt_q;

endmodule

// File: tb/tb_mat_outer_accum.sv
// Directed bench for mat_outer_accum with hand-computed results.
module tb_mat_outer_accum;
  import mat_pkg::*;

  localparam int MS = DATA_LEN * M * N;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_outer_accum_if bus ();

  mat_outer_accum dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  function automatic logic [MS-1:0] fill(logic [31:0] v);
    logic [MS-1:0] m;
    m = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        m[elem_lsb(r, c) +: DATA_LEN] = v;
    return m;
  endfunction

  function automatic logic [MS-1:0] pat(int k);
    logic [MS-1:0] m;
    int v;
    m = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        v = k + r - c;
        m[elem_lsb(r, c) +: DATA_LEN] = v;
      end
    return m;
  endfunction

  function automatic logic [MS-1:0] basic_exp();
    logic [MS-1:0] m;
    int v;
    m = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        v = 28 + 8 * r - 8 * c;
        m[elem_lsb(r, c) +: DATA_LEN] = v;
      end
    return m;
  endfunction

  function automatic int first_diff(logic [MS-1:0] a, logic [MS-1:0] b);
    for (int i = 0; i < M * N; i++)
      if (a[i*DATA_LEN +: DATA_LEN] !== b[i*DATA_LEN +: DATA_LEN])
        return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [MS-1:0] m);
    bus.i_valid = 1'b1;
    bus.i_mat_p = m;
    tick();
  endtask

  task automatic test_reset();
    logic [MS-1:0] e;
    int d;
    bus.i_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_mat_p = '0;
    #12;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_beat_cnt !== '0 || bus.o_mat_c !== '0) begin
      errors++;
      $display("FAIL reset_init valid=%b cnt=%0d want 0/0", bus.o_valid, bus.o_beat_cnt);
    end
    @(negedge clk) rstn = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) beat(fill(2));
    for (int k = 0; k < 3; k++) beat(fill(5));
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_beat_cnt !== 3'd3 || bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre cnt=%0d valid=%b want 3/1", bus.o_beat_cnt, bus.o_valid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_beat_cnt !== '0 || bus.o_mat_c !== '0) begin
      errors++;
      $display("FAIL reset_async valid=%b cnt=%0d want 0/0", bus.o_valid, bus.o_beat_cnt);
    end
    rstn = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) beat(fill(1));
    bus.i_valid = 1'b0;
    e = fill(8);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e) begin
      errors++;
      d = first_diff(bus.o_mat_c, e);
      $display("FAIL reset_after valid=%b elem %0d got %h want %h", bus.o_valid, d,
               bus.o_mat_c[d*DATA_LEN +: DATA_LEN], e[d*DATA_LEN +: DATA_LEN]);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [MS-1:0] e;
    elem_t x;
    int d;
    for (int k = 0; k < 8; k++) begin
      beat(pat(k));
      if (k == 3) begin
        checks++;
        if (bus.o_beat_cnt !== 3'd4 || bus.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_cnt cnt=%0d valid=%b want 4/0", bus.o_beat_cnt, bus.o_valid);
        end
      end
    end
    bus.i_valid = 1'b0;
    e = basic_exp();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e || bus.o_beat_cnt !== '0) begin
      errors++;
      d = first_diff(bus.o_mat_c, e);
      $display("FAIL basic_mat valid=%b cnt=%0d elem %0d got %h want %h", bus.o_valid,
               bus.o_beat_cnt, d, bus.o_mat_c[d*DATA_LEN +: DATA_LEN], e[d*DATA_LEN +: DATA_LEN]);
    end
    x = bus.o_mat_c[elem_lsb(7, 0) +: DATA_LEN];
    checks++;
    if (x !== 32'sd84) begin
      errors++;
      $display("FAIL basic_7_0 got %0d want 84", x);
    end
    x = bus.o_mat_c[elem_lsb(0, 7) +: DATA_LEN];
    checks++;
    if (x !== -32'sd28) begin
      errors++;
      $display("FAIL basic_0_7 got %0d want -28", x);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain valid=%b want 0", bus.o_valid);
    end
  endtask

  task automatic test_wrap();
    logic [MS-1:0] m, e;
    int d;
    m = '0;
    m[elem_lsb(2, 3) +: DATA_LEN] = 32'h7FFF_FFFF;
    e = '0;
    e[elem_lsb(2, 3) +: DATA_LEN] = 32'hFFFF_FFF8;
    for (int k = 0; k < 8; k++) beat(m);
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e) begin
      errors++;
      d = first_diff(bus.o_mat_c, e);
      $display("FAIL wrap valid=%b elem %0d got %h want %h", bus.o_valid, d,
               bus.o_mat_c[d*DATA_LEN +: DATA_LEN], e[d*DATA_LEN +: DATA_LEN]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [MS-1:0] e1, e2;
    e1 = fill(8);
    e2 = fill(16);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(fill(1));
    for (int k = 0; k < 8; k++) begin
      bus.i_valid = 1'b1;
      bus.i_mat_p = fill(2);
      #1;
      checks++;
      if (bus.o_ready !== (k < 7)) begin
        errors++;
        $display("FAIL bp_ready beat %0d got %b want %b", k, bus.o_ready, k < 7);
      end
      tick();
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e1 || bus.o_beat_cnt !== 3'd7) begin
      errors++;
      $display("FAIL bp_hold valid=%b cnt=%0d e00 got %h want %h", bus.o_valid,
               bus.o_beat_cnt, bus.o_mat_c[DATA_LEN-1:0], e1[DATA_LEN-1:0]);
    end
    bus.i_ready = 1'b1;
    #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release ready=%b want 1", bus.o_ready);
    end
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e2 || bus.o_beat_cnt !== '0) begin
      errors++;
      $display("FAIL bp_batch2 valid=%b cnt=%0d e00 got %h want %h", bus.o_valid,
               bus.o_beat_cnt, bus.o_mat_c[DATA_LEN-1:0], e2[DATA_LEN-1:0]);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain valid=%b want 0", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [MS-1:0] e;
    logic exp_v;
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      bus.i_valid = 1'b1;
      bus.i_mat_p = fill((i - 1) / 8 + 1);
      #1;
      checks++;
      if (bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready cycle %0d got %b want 1", i, bus.o_ready);
      end
      tick();
      exp_v = (i % 8 == 0);
      checks++;
      if (bus.o_valid !== exp_v) begin
        errors++;
        $display("FAIL stream_valid cycle %0d got %b want %b", i + 1, bus.o_valid, exp_v);
      end
      if (exp_v) begin
        e = fill(i);
        checks++;
        if (bus.o_mat_c !== e) begin
          errors++;
          $display("FAIL stream_mat cycle %0d e00 got %h want %h", i + 1,
                   bus.o_mat_c[DATA_LEN-1:0], e[DATA_LEN-1:0]);
        end
      end
    end
    bus.i_valid = 1'b0;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end valid=%b want 0", bus.o_valid);
    end
  endtask

  task automatic test_clear();
    logic [MS-1:0] e56, e16;
    int d;
    e56 = fill(56);
    e16 = fill(16);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 8; k++) beat(fill(7));
    for (int k = 0; k < 4; k++) beat(fill(3));
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_mat_p = fill(100);
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready got %b want 0", bus.o_ready);
    end
    tick();
    bus.i_clear = 1'b0;
    checks++;
    if (bus.o_beat_cnt !== '0 || bus.o_valid !== 1'b1 || bus.o_mat_c !== e56) begin
      errors++;
      $display("FAIL clr_hold cnt=%0d valid=%b e00 got %h want %h", bus.o_beat_cnt,
               bus.o_valid, bus.o_mat_c[DATA_LEN-1:0], e56[DATA_LEN-1:0]);
    end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 8; k++) beat(fill(2));
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_mat_c !== e16) begin
      errors++;
      d = first_diff(bus.o_mat_c, e16);
      $display("FAIL clr_result valid=%b elem %0d got %h want %h", bus.o_valid, d,
               bus.o_mat_c[d*DATA_LEN +: DATA_LEN], e16[d*DATA_LEN +: DATA_LEN]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
